// File: rtl/layer_sequencer.sv
// Purpose : fires NUM_STAGES layer blocks strictly in order over a level start / sticky done handshake.
// Latency : run sampled at edge N -> busy and stage_start[0] after N; per stage 1 arm + 1 detect + GAP_CYCLES minimum.
// Backpressure: each stage holds its start until its done is seen; a hung stage stalls the pass unless the watchdog is built in.
//
// Ports:
//   clk, reset_n (async, active-low)
//   run          request a full pass (sampled in IDLE only)
//   abort        synchronous abort, priority over run
//   stage_start  one-hot level start per stage      stage_done  sticky level done per stage
//   cur_stage    stage currently/last started       busy, all_done (1-cycle pulse)
//   total_cycles busy cycles of the last pass       error  sticky watchdog flag
// Build option: define SEQ_TIMEOUT_EN to enable the per-stage watchdog (TIMEOUT_CYCLES).
module layer_sequencer #(
    parameter int NUM_STAGES     = 6,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  abort,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [3:0]            cur_stage,
    output logic                  busy,
    output logic                  all_done,
    output logic [31:0]           total_cycles,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT_DONE,
        S_RELEASE,
        S_FINISH
    } state_t;

    localparam int              GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]      LAST_STAGE = 4'(NUM_STAGES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cur_stage_q, cur_stage_d;
    logic [NUM_STAGES-1:0]   start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    all_done_q, all_done_d;
    logic [31:0]             total_q, total_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    done_cur;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [31:0]  TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]             to_q, to_d;
    logic                    error_q, error_d;
`endif

    function automatic logic [NUM_STAGES-1:0] onehot(input logic [3:0] idx);
        onehot = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx == 4'(i)) onehot[i] = 1'b1;
        end
    endfunction

    // Select the done bit of the current stage without an out-of-range index.
    always_comb begin
        done_cur = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (cur_stage_q == 4'(i)) done_cur = stage_done[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_stage_d = cur_stage_q;
        start_d     = start_q;
        busy_d      = busy_q;
        all_done_d  = 1'b0;
        total_d     = total_q;
        gap_d       = gap_q;
`ifdef SEQ_TIMEOUT_EN
        to_d        = to_q;
        error_d     = error_q;
`endif
        // Saturating run-length counter; the accept branch below overrides it with zero.
        if (busy_q && (total_q != '1)) total_d = total_q + 32'd1;

        if (abort) begin
            state_d = S_IDLE;
            start_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d     = S_ASSERT;
                        cur_stage_d = 4'd0;
                        start_d     = onehot(4'd0);
                        busy_d      = 1'b1;
                        total_d     = '0;
`ifdef SEQ_TIMEOUT_EN
                        to_d        = '0;
                        error_d     = 1'b0;
`endif
                    end
                end
                // The done bit may still be high from the previous run; arm only once it is seen low.
                S_ASSERT: begin
                    if (!done_cur) state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (done_cur) begin
                        state_d = S_RELEASE;
                        start_d = '0;
                        gap_d   = '0;
                    end
                end
                S_RELEASE: begin
                    if (gap_q == GAP_LAST) begin
                        if (cur_stage_q == LAST_STAGE) begin
                            state_d    = S_FINISH;
                            all_done_d = 1'b1;
                            busy_d     = 1'b0;
                        end else begin
                            state_d     = S_ASSERT;
                            cur_stage_d = cur_stage_q + 4'd1;
                            start_d     = onehot(cur_stage_q + 4'd1);
`ifdef SEQ_TIMEOUT_EN
                            to_d        = '0;
`endif
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase

`ifdef SEQ_TIMEOUT_EN
            // Watchdog spans ASSERT and WAIT_DONE; a done arriving in the final cycle still wins.
            if ((state_q == S_ASSERT) || (state_q == S_WAIT_DONE)) begin
                to_d = to_q + 32'd1;
                if ((to_q == TO_LAST) && !((state_q == S_WAIT_DONE) && done_cur)) begin
                    state_d = S_IDLE;
                    start_d = '0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cur_stage_q <= 4'd0;
            start_q     <= '0;
            busy_q      <= 1'b0;
            all_done_q  <= 1'b0;
            total_q     <= '0;
            gap_q       <= '0;
`ifdef SEQ_TIMEOUT_EN
            to_q        <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_stage_q <= cur_stage_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            all_done_q  <= all_done_d;
            total_q     <= total_d;
            gap_q       <= gap_d;
`ifdef SEQ_TIMEOUT_EN
            to_q        <= to_d;
            error_q     <= error_d;
`endif
        end
    end

    assign stage_start  = start_q;
    assign cur_stage    = cur_stage_q;
    assign busy         = busy_q;
    assign all_done     = all_done_q;
    assign total_cycles = total_q;
`ifdef SEQ_TIMEOUT_EN
    assign error        = error_q;
`else
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Purpose : directed self-checking bench for layer_sequencer (3 stages, gap 2, watchdog 20).
// Latency : stage models drop done one cycle after start and raise it five cycles later.
// Backpressure: stage models may be told to clear late or hang to exercise arming, abort and the watchdog.
module tb_layer_sequencer;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0;
    logic          abort = 1'b0;
    logic [NS-1:0] stage_start;
    logic [NS-1:0] sd = '0;
    logic [3:0]    cur_stage;
    logic          busy;
    logic          all_done;
    logic [31:0]   total_cycles;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    // stage model controls
    int clr_at [NS] = '{1, 1, 1};
    bit hang   [NS] = '{0, 0, 0};
    int cnt    [NS] = '{0, 0, 0};

    // start monitor
    int            log_q [64];
    int            log_n = 0;
    int            overlap = 0;
    logic [NS-1:0] prev_start = '0;

    layer_sequencer #(
        .NUM_STAGES    (NS),
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .abort       (abort),
        .stage_start (stage_start),
        .stage_done  (sd),
        .cur_stage   (cur_stage),
        .busy        (busy),
        .all_done    (all_done),
        .total_cycles(total_cycles),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Layer block model: done is sticky, cleared clr_at cycles into start, raised five cycles after that.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!stage_start[i]) begin
                cnt[i] <= 0;
            end else begin
                cnt[i] <= cnt[i] + 1;
                if (cnt[i] + 1 == clr_at[i]) sd[i] <= 1'b0;
                if ((cnt[i] + 1 == clr_at[i] + 5) && !hang[i]) sd[i] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if ((stage_start != prev_start) && (stage_start != '0)) begin
            for (int i = 0; i < NS; i++) begin
                if (stage_start[i] && (log_n < 64)) log_q[log_n] = i;
            end
            log_n = log_n + 1;
        end
        if ($countones(stage_start) > 1) overlap = overlap + 1;
        prev_start = stage_start;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input logic [NS-1:0] v, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (stage_start === v) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // Counts negedges with busy high from now until all_done is seen.
    task automatic wait_done(input string tag, output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (all_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy === 1'b1) cyc++;
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    initial begin
        int cyc;

        // reset values
        #3;
        chk("rst_start",    32'(stage_start),  32'd0);
        chk("rst_cur",      32'(cur_stage),    32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_all_done", 32'(all_done),     32'd0);
        chk("rst_total",    total_cycles,      32'd0);
        chk("rst_error",    32'(error),        32'd0);
        tick();
        reset_n = 1'b1;
        tick(2);

        // nominal pass: 7 start-high cycles + 2 gap per stage -> 27 busy cycles
        pulse_run();
        chk("nom_busy",  32'(busy),        32'd1);
        chk("nom_start", 32'(stage_start), 32'b001);
        chk("nom_cur",   32'(cur_stage),   32'd0);
        wait_done("nom_wait", cyc);
        chk("nom_total",     total_cycles, 32'd27);
        chk("nom_total_tb",  total_cycles, 32'(cyc));
        chk("nom_busy_end",  32'(busy),    32'd0);
        chk("nom_cur_end",   32'(cur_stage), 32'd2);
        chk("nom_log_n",     32'(log_n),   32'd3);
        chk("nom_order0",    32'(log_q[0]), 32'd0);
        chk("nom_order1",    32'(log_q[1]), 32'd1);
        chk("nom_order2",    32'(log_q[2]), 32'd2);
        tick();
        chk("nom_pulse_one", 32'(all_done), 32'd0);
        chk("nom_total_hold", total_cycles, 32'd27);

        // back-to-back: run the cycle after all_done starts a new pass from zero
        pulse_run();
        chk("b2b_busy",  32'(busy),        32'd1);
        chk("b2b_total", total_cycles,     32'd0);
        chk("b2b_start", 32'(stage_start), 32'b001);
        tick(3);
        pulse_run();   // ignored while busy
        wait_done("b2b_wait", cyc);
        chk("b2b_total_end", total_cycles, 32'd27);
        tick(3);
        chk("b2b_no_relaunch_busy",  32'(busy),        32'd0);
        chk("b2b_no_relaunch_start", 32'(stage_start), 32'd0);

        // stale done on stage 1 (still high from last pass), cleared late
        clr_at[1] = 3;
        pulse_run();
        wait_start(3'b010, "stale_reach");
        tick(4);
        chk("stale_hold_k4", 32'(stage_start), 32'b010);
        tick(4);
        chk("stale_hold_k8", 32'(stage_start), 32'b010);
        tick();
        chk("stale_drop_k9", 32'(stage_start), 32'b000);
        wait_done("stale_wait", cyc);
        chk("stale_total", total_cycles, 32'd29);
        clr_at[1] = 1;
        tick(2);

        // abort in WAIT_DONE of stage 1
        pulse_run();
        wait_start(3'b010, "abort_reach");
        tick(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_start",    32'(stage_start), 32'd0);
        chk("abort_busy",     32'(busy),        32'd0);
        chk("abort_all_done", 32'(all_done),    32'd0);
        chk("abort_cur",      32'(cur_stage),   32'd1);
        chk("abort_total",    total_cycles,     32'd13);
        tick(2);
        chk("abort_no_pulse", 32'(all_done),    32'd0);
        chk("abort_total_hold", total_cycles,   32'd13);
        pulse_run();
        chk("rerun_start", 32'(stage_start), 32'b001);
        chk("rerun_cur",   32'(cur_stage),   32'd0);
        chk("rerun_busy",  32'(busy),        32'd1);
        wait_done("rerun_wait", cyc);
        chk("rerun_total", total_cycles, 32'd27);
        tick(2);

        // asynchronous reset while stage 0 start is high
        pulse_run();
        chk("arst_pre_start", 32'(stage_start), 32'b001);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_start",    32'(stage_start), 32'd0);
        chk("arst_busy",     32'(busy),        32'd0);
        chk("arst_cur",      32'(cur_stage),   32'd0);
        chk("arst_total",    total_cycles,     32'd0);
        chk("arst_all_done", 32'(all_done),    32'd0);
        tick();
        reset_n = 1'b1;
        tick(2);

`ifdef SEQ_TIMEOUT_EN
        // watchdog: stage 2 never raises done
        hang[2] = 1'b1;
        pulse_run();
        wait_start(3'b100, "to_reach");
        tick(19);
        chk("to_err_before",   32'(error),       32'd0);
        chk("to_start_before", 32'(stage_start), 32'b100);
        tick();
        chk("to_err",      32'(error),       32'd1);
        chk("to_start",    32'(stage_start), 32'd0);
        chk("to_busy",     32'(busy),        32'd0);
        chk("to_cur",      32'(cur_stage),   32'd2);
        chk("to_all_done", 32'(all_done),    32'd0);
        tick(3);
        chk("to_err_sticky", 32'(error), 32'd1);
        hang[2] = 1'b0;
        pulse_run();
        chk("to_err_clear", 32'(error), 32'd0);
        chk("to_rerun_busy", 32'(busy), 32'd1);
        wait_done("to_rerun_wait", cyc);
        chk("to_rerun_total", total_cycles, 32'd27);
`else
        // no watchdog: a hung stage stalls until abort
        hang[2] = 1'b1;
        pulse_run();
        wait_start(3'b100, "stall_reach");
        tick(30);
        chk("stall_start", 32'(stage_start), 32'b100);
        chk("stall_busy",  32'(busy),        32'd1);
        chk("stall_error", 32'(error),       32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("stall_abort_busy",  32'(busy),        32'd0);
        chk("stall_abort_start", 32'(stage_start), 32'd0);
        hang[2] = 1'b0;
`endif
        tick(2);
        chk("overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Initiator side of the level `start` / sticky `done` handshake used by every inference layer (conv, pool, fc). It fires NUM_STAGES layer blocks strictly in order, one at a time: it raises each stage's `start`, waits for that stage's completion, releases `start`, and moves to the next stage. It sits between the top-level inference trigger and the layer chain ending at the fully connected layers, and reports run completion and a total cycle count.

## Interface
- NUM_STAGES, 6, number of layer blocks sequenced (1..16).
- GAP_CYCLES, 2, cycles `stage_start` is held low between stages (min 1).
- TIMEOUT_CYCLES, 1000000, per-stage watchdog limit; used only when SEQ_TIMEOUT_EN is defined.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- run  in  1  request a full pass; sampled only in IDLE.
- abort  in  1  synchronous abort; drops all starts and returns to IDLE.
- stage_start  out  NUM_STAGES  one-hot (or zero) level start to each layer.
- stage_done  in  NUM_STAGES  sticky level done from each layer.
- cur_stage  out  4  index of the stage currently started or last started.
- busy  out  1  high from run acceptance until all_done or abort.
- all_done  out  1  one-cycle pulse when the last stage has been released.
- total_cycles  out  32  cycles from run acceptance to all_done; held until the next run.
- error  out  1  sticky watchdog flag (0 when SEQ_TIMEOUT_EN is undefined).

## Operation
- States: IDLE, ASSERT, WAIT_DONE, RELEASE, FINISH.
- IDLE: `run`=1 and `abort`=0 → clear total_cycles, clear error, cur_stage=0, go to ASSERT. `run` while busy is ignored.
- ASSERT: stage_start[cur_stage]=1. Arming rule: a stage's `done` is sticky from its previous run, and the stage clears it one cycle after it sees `start`. The sequencer therefore arms only after it samples stage_done[cur_stage]=0 while start is high, then goes to WAIT_DONE.
- WAIT_DONE: start held high; on stage_done[cur_stage]=1 go to RELEASE. done bits of non-current stages are ignored.
- RELEASE: all starts 0 for exactly GAP_CYCLES cycles; gap counter counts 0..GAP_CYCLES-1. Then either cur_stage+1 → ASSERT, or, if cur_stage==NUM_STAGES-1, go to FINISH.
- FINISH: all_done=1 for one cycle, busy=0, go to IDLE.
- abort (any state): next cycle all starts 0, busy=0, state IDLE, no all_done pulse. cur_stage and total_cycles hold their values. abort has priority over run.
- total_cycles increments every cycle busy=1 and saturates at 0xFFFFFFFF.
- Reset values: stage_start=0, cur_stage=0, busy=0, all_done=0, total_cycles=0, error=0, state IDLE. Reset mid-run drops `start` immediately (asynchronous).

## Timing
- All outputs are registered.
- run sampled high at edge N → busy and stage_start[0] high after edge N.
- Minimum per-stage overhead: 1 arming cycle + 1 detect cycle + GAP_CYCLES.
- done sampled high at edge M → start low after edge M.
- all_done asserts the cycle after the last gap cycle.

## Configuration
- SEQ_TIMEOUT_EN defined: a per-stage counter is cleared on entry to ASSERT and counts during ASSERT and WAIT_DONE. On reaching TIMEOUT_CYCLES: error=1 (sticky), starts dropped, busy=0, state IDLE, cur_stage holds the hung stage, no all_done. error clears on the next accepted run.
- SEQ_TIMEOUT_EN undefined: no counter; error is tied to 0; a hung stage stalls the sequencer indefinitely until abort or reset.

## Test plan
- Nominal pass, NUM_STAGES=3, GAP_CYCLES=2, each stage model drops done 1 cycle after start and raises it 5 cycles later → starts fire in order 0,1,2 and never overlap. all_done pulses once. total_cycles is the count measured by a bench cycle counter.
- Stale done: stage 1 done preset high before run → sequencer does not advance until stage 1 done has fallen and risen again.
- Back-to-back runs: second run pulsed while busy → ignored. Run pulsed the cycle after all_done → new pass; total_cycles restarts from 0.
- Abort during WAIT_DONE of stage 1 → next cycle stage_start=0, busy=0, no all_done, cur_stage=1. A following run restarts at stage 0.
- Async reset asserted mid-ASSERT → stage_start=0 before the next clock edge; all outputs at reset values.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=20 and stage 2 never raising done → error=1 after 20 cycles in stage 2, start dropped, cur_stage=2. The next run clears error.
